// File: rtl/uart_apb_arbiter.sv
// Round-robin two-requester APB master fronting the EF_UART_APB slave port.
// Each requester gets one registered done pulse carrying read data or a timeout error.
module uart_apb_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_err,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic          PSEL,
  output logic          PENABLE,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  output logic          busy,
  output logic          grant
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          sel_c;
  logic          finish_c;
  logic          timeout_c;
  logic [DW-1:0] rd_c;

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = err0_q;
    err1_d    = err1_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    sel_c     = 1'b0;
    finish_c  = 1'b0;
    timeout_c = 1'b0;
    rd_c      = '0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester not served last wins
          sel_c     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          grant_d   = sel_c;
          paddr_d   = sel_c ? req1_addr  : req0_addr;
          pwdata_d  = sel_c ? req1_wdata : req0_wdata;
          pwrite_d  = sel_c ? req1_write : req0_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          finish_c = 1'b1;
          rd_c     = pwrite_q ? '0 : PRDATA;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          finish_c  = 1'b1;
          timeout_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (finish_c) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          last_d    = grant_q;
          state_d   = S_DONE;
          if (grant_q) begin
            rdata1_d = rd_c;
            err1_d   = timeout_c;
            done1_d  = 1'b1;
          end else begin
            rdata0_d = rd_c;
            err0_d   = timeout_c;
            done0_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PWRITE     = pwrite_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule
